// File: rtl/rf_pkg.sv
// Shared constants and helpers for the banked register file and its scoreboard.
package rf_pkg;

  localparam int BANK_INT = 0;
  localparam int BANK_FP  = 1;

  // Bank select width never collapses to zero, even for a single bank.
  function automatic int bank_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic logic bank_valid(input int unsigned bank, input int unsigned num_banks);
    return bank < num_banks;
  endfunction

  function automatic logic is_zero_reg(input int unsigned bank, input int unsigned addr,
                                       input int unsigned mask);
    return (addr == 0) && (bank < 32) && mask[bank];
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with reserve-over-write priority and a running busy count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int          DEPTH          = 32,
  parameter int          NUM_BANKS      = 2,
  parameter int unsigned ZERO_BANK_MASK = 'b01,
  localparam int         ADDR_W         = $clog2(DEPTH),
  localparam int         BANK_W         = bank_width(NUM_BANKS),
  localparam int         CNT_W          = $clog2(NUM_BANKS * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [BANK_W-1:0] rsv_bank,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [BANK_W-1:0] lk_bank1,
  input  logic [ADDR_W-1:0] lk_addr1,
  input  logic [BANK_W-1:0] lk_bank2,
  input  logic [ADDR_W-1:0] lk_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [NUM_BANKS-1:0][DEPTH-1:0] busy_q;
  logic [NUM_BANKS-1:0][DEPTH-1:0] busy_d;
  logic wr_hit, rsv_hit, same_reg;
  logic lk_ok1, lk_ok2;
  logic inc, dec;

  assign wr_hit  = wr_en && bank_valid(32'(wr_bank), NUM_BANKS)
                   && !is_zero_reg(32'(wr_bank), 32'(wr_addr), ZERO_BANK_MASK);
  assign rsv_hit = rsv_en && bank_valid(32'(rsv_bank), NUM_BANKS)
                   && !is_zero_reg(32'(rsv_bank), 32'(rsv_addr), ZERO_BANK_MASK);
  assign same_reg = (wr_bank == rsv_bank) && (wr_addr == rsv_addr);

  assign lk_ok1 = bank_valid(32'(lk_bank1), NUM_BANKS)
                  && !is_zero_reg(32'(lk_bank1), 32'(lk_addr1), ZERO_BANK_MASK);
  assign lk_ok2 = bank_valid(32'(lk_bank2), NUM_BANKS)
                  && !is_zero_reg(32'(lk_bank2), 32'(lk_addr2), ZERO_BANK_MASK);

  // Reserve is applied after the write: it belongs to the younger instruction.
  always_comb begin
    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (wr_hit) begin
      busy_d[wr_bank][wr_addr] = 1'b0;
      dec = busy_q[wr_bank][wr_addr];
    end
    if (rsv_hit) begin
      busy_d[rsv_bank][rsv_addr] = 1'b1;
      inc = !busy_q[rsv_bank][rsv_addr];
      if (wr_hit && same_reg) dec = 1'b0;
    end
  end

  // Lookups see the post-edge state so they line up with bypassed read data.
  assign busy1 = lk_ok1 ? busy_d[lk_bank1][lk_addr1] : 1'b0;
  assign busy2 = lk_ok2 ? busy_d[lk_bank2][lk_addr2] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= busy_cnt + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/banked_reg_file.sv
// Multi-bank architectural register file: two registered read ports with
// same-cycle write bypass, one write port, and a busy scoreboard for issue.
module banked_reg_file
  import rf_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          DEPTH          = 32,
  parameter int          NUM_BANKS      = 2,
  parameter int unsigned ZERO_BANK_MASK = 'b01,
  localparam int         ADDR_W         = $clog2(DEPTH),
  localparam int         BANK_W         = bank_width(NUM_BANKS),
  localparam int         CNT_W          = $clog2(NUM_BANKS * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] rd_bank1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [BANK_W-1:0] rd_bank2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [BANK_W-1:0] rsv_bank,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [DATA_W-1:0] regs [NUM_BANKS][DEPTH];
  logic              wr_hit;
  logic              rd_ok1, rd_ok2;
  logic              byp1, byp2;
  logic [DATA_W-1:0] data1_p0, data2_p0;
  logic              busy1_p0, busy2_p0;

  assign wr_hit = wr_en && bank_valid(32'(wr_bank), NUM_BANKS)
                  && !is_zero_reg(32'(wr_bank), 32'(wr_addr), ZERO_BANK_MASK);

  assign rd_ok1 = bank_valid(32'(rd_bank1), NUM_BANKS)
                  && !is_zero_reg(32'(rd_bank1), 32'(rd_addr1), ZERO_BANK_MASK);
  assign rd_ok2 = bank_valid(32'(rd_bank2), NUM_BANKS)
                  && !is_zero_reg(32'(rd_bank2), 32'(rd_addr2), ZERO_BANK_MASK);

  assign byp1 = wr_hit && (wr_bank == rd_bank1) && (wr_addr == rd_addr1);
  assign byp2 = wr_hit && (wr_bank == rd_bank2) && (wr_addr == rd_addr2);

  rf_scoreboard #(
    .DEPTH          (DEPTH),
    .NUM_BANKS      (NUM_BANKS),
    .ZERO_BANK_MASK (ZERO_BANK_MASK)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_bank (rsv_bank),
    .rsv_addr (rsv_addr),
    .lk_bank1 (rd_bank1),
    .lk_addr1 (rd_addr1),
    .lk_bank2 (rd_bank2),
    .lk_addr2 (rd_addr2),
    .busy1    (busy1_p0),
    .busy2    (busy2_p0),
    .busy_cnt (busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int d = 0; d < DEPTH; d++) begin
          regs[b][d] <= '0;
        end
      end
    end else if (wr_hit) begin
      regs[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Stage p0: select between bypass and storage; invalid selects read as zero.
  always_comb begin
    data1_p0 = '0;
    data2_p0 = '0;
    if (rd_ok1) data1_p0 = byp1 ? wr_data : regs[rd_bank1][rd_addr1];
    if (rd_ok2) data2_p0 = byp2 ? wr_data : regs[rd_bank2][rd_addr2];
  end

  // Stage p1: registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_busy1 <= 1'b0;
      rd_busy2 <= 1'b0;
    end else begin
      rd_data1 <= data1_p0;
      rd_data2 <= data2_p0;
      rd_busy1 <= busy1_p0;
      rd_busy2 <= busy2_p0;
    end
  end

endmodule
